chunk_serial_subtractor: RTL and testbench
==========================================

// Module: chunk_serial_subtractor
// PURPOSE
//  Multi-cycle unsigned subtractor: y = a - b - bin mod 2^N, with borrow-out.
//  One K-bit chunk per cycle, LSB chunk first, borrow held in a flop between
//  chunks. Complements the combinational conditional_sum adder where area
//  matters more than latency. Valid/ready on both input and result sides.
// PARAMETERS
//  N  64  operand width; N % K == 0 is required (elaboration-time $error)
//  K   8  chunk width, bits subtracted per cycle; CHUNKS = N/K (localparam)
// PORTS
//  clk        in   1  single clock; all state on rising edge
//  rst_n      in   1  synchronous, active-low reset
//  in_valid   in   1  operands a, b, bin valid
//  in_ready   out  1  block can accept operands
//  a          in   N  minuend
//  b          in   N  subtrahend
//  bin        in   1  borrow-in
//  out_valid  out  1  y/bout valid
//  out_ready  in   1  consumer accepts result
//  y          out  N  difference
//  bout       out  1  borrow-out (1 iff a < b + bin, unsigned)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, cnt=0, y=0, bout=0, out_valid=0.
//   in_ready is 0 while rst_n=0; inputs ignored during reset.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. in_valid&in_ready -> latch a, b, borrow<=bin, cnt<=0,
//     go RUN. No other transitions.
//   RUN: in_ready=0. Each cycle: chunk {d,bo} = a[K-1:0]-b[K-1:0]-borrow;
//     y <= {d, y[N-1:K]}; a,b shift right by K; borrow<=bo; cnt<=cnt+1.
//     When cnt==CHUNKS-1: bout<=bo, go DONE. CHUNKS==1 -> one RUN cycle.
//   DONE: out_valid=1, y/bout held stable. out_ready=1 -> IDLE next cycle.
//     out_ready=0 -> stay DONE indefinitely; in_valid ignored.
//  Latency: accept edge T -> out_valid=1 at T+CHUNKS. Throughput: one op per
//   CHUNKS+2 cycles with out_ready=1 (no accept in DONE).
//  y/bout change only in RUN; out_valid never drops without out_ready.
//  Reset mid-RUN or mid-DONE: abort, outputs return to reset values next edge;
//   pending result is lost, no out_valid pulse.
//  Chunk arithmetic: K-bit add a + ~b + ~borrow; bo = ~carry_out.
//   cnt width $clog2(CHUNKS) (min 1).
// STRUCTURE
//  Shared package: state enum {IDLE,RUN,DONE} as 2-bit typedef; helper
//   function for CHUNKS and counter width.
//  Sub-module: chunk_subtract #(K) -- combinational K-bit a-b-bin, built as
//   conditional_sum #(K,K) with inverted b and cin=~bin, bout=~cout.
//  Top holds FSM, counter, operand/result shift registers, borrow flop.
// TESTING (N=64, K=8 unless noted)
//  a=5,b=3,bin=0 -> y=2, bout=0; out_valid exactly 8 cycles after accept.
//  a=0,b=1,bin=0 -> y=64'hFFFF_FFFF_FFFF_FFFF, bout=1 (borrow through all
//   chunks).
//  a=64'h100,b=0,bin=1 -> y=64'hFF, bout=0 (borrow crosses chunk boundary).
//  Hold out_ready=0 for 5 cycles in DONE -> y/bout/out_valid stable,
//   in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next.
//  rst_n=0 at cnt=3 -> next cycle out_valid=0, y=0, in_ready=1 after release;
//   following op a=10,b=20 -> y=2^64-10, bout=1.
//  1000 random ops, random in_valid/out_ready, vs model a-b-bin; repeat with
//   K=64 (CHUNKS=1) and K=1 (CHUNKS=64).

Source files
------------

// File: rtl/chunk_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the chunk-serial subtractor.
package chunk_serial_subtractor_pkg;

   // Controller states: waiting for operands, subtracting chunks, holding result.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Number of K-bit chunks in an N-bit operand.
   function automatic int unsigned num_chunks(input int unsigned n, input int unsigned k);
      return (k == 0) ? 0 : n / k;
   endfunction

   // Chunk counter width; a single-chunk build still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned chunks);
      return (chunks > 1) ? $clog2(chunks) : 1;
   endfunction

endpackage

// File: rtl/chunk_subtract.sv
// Combinational K-bit a - b - bin, formed as a + ~b + ~bin; borrow-out is the
// inverted carry-out of that addition.
module chunk_subtract #(
   parameter int unsigned K = 8
) (
   input  logic [K-1:0] a_i,
   input  logic [K-1:0] b_i,
   input  logic         bin_i,
   output logic [K-1:0] d_o,
   output logic         bout_o
);

   logic [K:0] sum;

   assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{K{1'b0}}, ~bin_i};
   assign d_o    = sum[K-1:0];
   assign bout_o = ~sum[K];

endmodule

// File: rtl/chunk_serial_subtractor.sv
// Multi-cycle unsigned subtractor: one K-bit chunk per cycle, LSB chunk first,
// with the inter-chunk borrow held in a flop. Valid/ready on both sides.
module chunk_serial_subtractor
   import chunk_serial_subtractor_pkg::*;
#(
   parameter int unsigned N = 64,
   parameter int unsigned K = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic         bout
);

   localparam int unsigned Chunks = num_chunks(N, K);
   localparam int unsigned CntW   = cnt_width(Chunks);

   if (K == 0 || (N % K) != 0) begin : g_bad_params
      $error("chunk_serial_subtractor: N must be a non-zero multiple of K");
   end

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [N-1:0]    y_q, y_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            borrow_q, borrow_d;
   logic            bout_q, bout_d;

   logic [K-1:0]    diff;
   logic            chunk_bo;
   logic [N-1:0]    y_shift;

   chunk_subtract #(
      .K (K)
   ) u_chunk (
      .a_i    (a_q[K-1:0]),
      .b_i    (b_q[K-1:0]),
      .bin_i  (borrow_q),
      .d_o    (diff),
      .bout_o (chunk_bo)
   );

   // New chunk enters at the top so the LSB chunk ends up at the bottom.
   if (K == N) begin : g_single
      assign y_shift = diff;
   end else begin : g_multi
      assign y_shift = {diff, y_q[N-1:K]};
   end

   // State, operand, result and borrow registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         y_q      <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
      end
   end

   // Next-state and datapath control; handshake outputs decoded from state.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      y_d       = y_q;
      cnt_d     = cnt_q;
      borrow_d  = borrow_q;
      bout_d    = bout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = rst_n;
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            y_d      = y_shift;
            a_d      = a_q >> K;
            b_d      = b_q >> K;
            borrow_d = chunk_bo;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(Chunks - 1)) begin
               bout_d  = chunk_bo;
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign y    = y_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_chunk_serial_subtractor.sv
// Self-checking bench: directed scenarios on a K=8 instance, then random
// valid/ready traffic on K=8, K=64 and K=1 instances against a 65-bit model.
module tb_chunk_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        bin = 1'b0;
   logic        in_valid [3];
   logic        out_ready [3];
   logic        in_ready [3];
   logic        out_valid [3];
   logic [63:0] y [3];
   logic        bout [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chunk_serial_subtractor #(.N(64), .K(8)) u_dut8 (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid[0]), .in_ready (in_ready[0]),
      .a (a), .b (b), .bin (bin), .out_valid (out_valid[0]), .out_ready (out_ready[0]),
      .y (y[0]), .bout (bout[0])
   );

   chunk_serial_subtractor #(.N(64), .K(64)) u_dut64 (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid[1]), .in_ready (in_ready[1]),
      .a (a), .b (b), .bin (bin), .out_valid (out_valid[1]), .out_ready (out_ready[1]),
      .y (y[1]), .bout (bout[1])
   );

   chunk_serial_subtractor #(.N(64), .K(1)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid[2]), .in_ready (in_ready[2]),
      .a (a), .b (b), .bin (bin), .out_valid (out_valid[2]), .out_ready (out_ready[2]),
      .y (y[2]), .bout (bout[2])
   );

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: full-precision difference; bit 64 is the borrow-out.
   function automatic logic [64:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                         input logic mbin);
      return {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
   endfunction

   // Drive one op into the K=8 instance; returns cycles from accept edge to out_valid.
   task automatic op8(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                      output int lat);
      @(negedge clk);
      a = ta; b = tb; bin = tbin; in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      lat = 0;
      while (!out_valid[0] && lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
      end
   endtask

   // Hand the result off and confirm the block is idle again.
   task automatic release8(input string tag);
      @(negedge clk);
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      check64({tag, "_ov_drop"}, 64'(out_valid[0]), 64'd0);
      check64({tag, "_in_ready"}, 64'(in_ready[0]), 64'd1);
      @(negedge clk);
      out_ready[0] = 1'b0;
   endtask

   task automatic rand_run(input int d, input int nops);
      logic [64:0] q [$];
      logic [64:0] exp;
      logic [63:0] hold_y;
      logic        hold_b;
      logic        holding;
      int          done_ops;
      int          cyc;
      holding  = 1'b0;
      done_ops = 0;
      cyc      = 0;
      while (done_ops < nops && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (holding) begin
            check64($sformatf("hold_ov_%0d", d), 64'(out_valid[d]), 64'd1);
            check64($sformatf("hold_y_%0d", d), y[d], hold_y);
            check64($sformatf("hold_bout_%0d", d), 64'(bout[d]), 64'(hold_b));
         end
         in_valid[d]  = ($urandom_range(3) != 0);
         out_ready[d] = ($urandom_range(1) != 0);
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         bin = ($urandom_range(1) != 0);
         if ($urandom_range(15) == 0) b = a;
         if ($urandom_range(15) == 0) a = '0;
         if (in_valid[d] && in_ready[d]) q.push_back(model(a, b, bin));
         if (out_valid[d] && out_ready[d]) begin
            if (q.size() == 0) begin
               check64($sformatf("spurious_result_%0d", d), 64'd1, 64'd0);
            end else begin
               exp = q.pop_front();
               check64($sformatf("rand_y_%0d", d), y[d], exp[63:0]);
               check64($sformatf("rand_bout_%0d", d), 64'(bout[d]), 64'(exp[64]));
            end
            done_ops++;
         end
         holding = out_valid[d] && !out_ready[d];
         hold_y  = y[d];
         hold_b  = bout[d];
      end
      check64($sformatf("rand_ops_done_%0d", d), 64'(done_ops), 64'(nops));
      @(negedge clk);
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
   endtask

   initial begin
      int          lat;
      logic [63:0] sy;
      logic        sb;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
      end

      // Reset state, with a stray in_valid that must be ignored.
      in_valid[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check64("rst_in_ready", 64'(in_ready[0]), 64'd0);
      check64("rst_out_valid", 64'(out_valid[0]), 64'd0);
      check64("rst_y", y[0], 64'd0);
      check64("rst_bout", 64'(bout[0]), 64'd0);
      @(negedge clk);
      in_valid[0] = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check64("idle_in_ready", 64'(in_ready[0]), 64'd1);

      // 5 - 3 - 0 and its latency.
      op8(64'd5, 64'd3, 1'b0, lat);
      check64("lat_5_3", 64'(lat), 64'd8);
      check64("y_5_3", y[0], 64'd2);
      check64("bout_5_3", 64'(bout[0]), 64'd0);
      release8("r1");

      // Borrow ripples through every chunk.
      op8(64'd0, 64'd1, 1'b0, lat);
      check64("y_0_1", y[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check64("bout_0_1", 64'(bout[0]), 64'd1);
      release8("r2");

      // Borrow-in crosses a chunk boundary.
      op8(64'h100, 64'd0, 1'b1, lat);
      check64("y_100", y[0], 64'hFF);
      check64("bout_100", 64'(bout[0]), 64'd0);

      // Backpressure in DONE: outputs frozen, new operands ignored.
      sy = y[0];
      sb = bout[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b1;
         a = 64'hDEAD_BEEF_0000_1234;
         b = 64'd7;
         @(posedge clk);
         #1;
         check64("hold_out_valid", 64'(out_valid[0]), 64'd1);
         check64("hold_in_ready", 64'(in_ready[0]), 64'd0);
         check64("hold_y", y[0], sy);
         check64("hold_bout", 64'(bout[0]), 64'(sb));
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      release8("r3");

      // Reset mid-RUN after three chunks.
      @(negedge clk);
      a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; bin = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check64("abort_out_valid", 64'(out_valid[0]), 64'd0);
      check64("abort_y", y[0], 64'd0);
      check64("abort_bout", 64'(bout[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check64("abort_in_ready", 64'(in_ready[0]), 64'd1);
      op8(64'd10, 64'd20, 1'b0, lat);
      check64("y_10_20", y[0], 64'hFFFF_FFFF_FFFF_FFF6);
      check64("bout_10_20", 64'(bout[0]), 64'd1);
      release8("r4");

      // Random traffic on each chunk width.
      rand_run(0, 1000);
      rand_run(1, 1000);
      rand_run(2, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
